bmem_burst_responder: RTL and testbench

// - Responder end of the 64-bit burst-memory (bmem) interface driven by the OoO core's DRAM wrapper.
// - Accepts single-cycle line reads and 4-beat line writes, then returns each read as 4 in-order beats.
// - Returns reads after a programmable latency; the bmem_raddr tag lets the initiator route beats.
// - Sits below the wrapper as a synthesizable memory model/controller stub for sim and FPGA bring-up.

---
 rtl/bmem_burst_responder_if.sv | 22 ++
 rtl/bmem_burst_responder.sv | 244 ++++++++++++++++++++++++
 tb/tb_bmem_burst_responder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bmem_burst_responder_if.sv
// Burst-memory (bmem) request/response bundle between the DRAM wrapper
// (master) and the responder (slave).
interface bmem_burst_responder_if;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_write;
  logic [63:0] bmem_wdata;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;

  modport master (
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport slave (
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/bmem_burst_responder.sv
// bmem_burst_responder: responder end of the 64-bit burst-memory interface.
// Accepts single-cycle line reads and 4-beat line writes into a 256-bit-line
// store, and returns each read as 4 in-order beats after LATENCY cycles.
// Optional feature macro: BMEM_BEAT_GAP_EN inserts LFSR-driven bubble cycles
// between return beats; when undefined, beats are strictly consecutive.
module bmem_burst_responder #(
  parameter int MEM_LINES = 1024,
  parameter int RD_DEPTH  = 4,
  parameter int LATENCY   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bmem_burst_responder_if.slave  bus,
  output logic                   proto_err
);

  localparam int LINE_W = $clog2(MEM_LINES);
  localparam int PTR_W  = $clog2(RD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TMR_W  = $clog2(LATENCY + 1);

  typedef enum logic {IDLE, BURST} state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                 run;          // low during and for one edge after reset
  logic [1:0]           wr_cnt;       // next expected write beat, 0 = no burst open
  logic [LINE_W-1:0]    wr_line;      // line latched at write beat 0
  logic                 wr_busy;

  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;
  logic                 full;

  logic [26:0]          q_addr [RD_DEPTH];
  logic [255:0]         q_data [RD_DEPTH];
  logic [TMR_W-1:0]     timer_of [RD_DEPTH];

  logic                 fill_pend;    // snapshot of last cycle's read lands now
  logic [PTR_W-1:0]     fill_ptr;
  logic [255:0]         snap;

  state_t               state;
  state_t               state_next;
  logic [1:0]           beat;
  logic [1:0]           beat_next;
  logic                 stall;
  logic                 pop;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [LINE_W-1:0] req_line;
  logic [LINE_W-1:0] wr_tgt;
  logic rd_req, wr_req, collide, rd_busy_err, wr_line_err, push, wr_do;
  logic unused_addr_bits;

  assign req_line         = bus.bmem_addr[5 +: LINE_W];
  assign unused_addr_bits = ^bus.bmem_addr[4:0];

  assign wr_busy     = (wr_cnt != 2'd0);
  assign full        = (count == CNT_W'(RD_DEPTH));
  // Ready depends only on internal state so the initiator never sees a
  // combinational path from its own request back to the accept.
  assign bus.bmem_ready = run && (!full || wr_busy);

  assign rd_req      = bus.bmem_ready && bus.bmem_read;
  assign wr_req      = bus.bmem_ready && bus.bmem_write;
  assign collide     = rd_req && wr_req;
  assign rd_busy_err = rd_req && !wr_req && wr_busy;
  assign push        = rd_req && !wr_req && !wr_busy;
  assign wr_line_err = wr_req && !rd_req && wr_busy && (req_line != wr_line);
  assign wr_do       = wr_req && !rd_req && !wr_line_err;
  assign wr_tgt      = wr_busy ? wr_line : req_line;

  // Leaves reset one edge after rst_n releases so ready is low out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Write beat counter; the line is captured on beat 0 and held for the burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= 2'd0;
      wr_line <= '0;
    end else if (wr_do) begin
      wr_cnt <= wr_cnt + 2'd1;
      if (!wr_busy) wr_line <= req_line;
    end
  end

  // Sticky protocol error: only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     proto_err <= 1'b0;
    else if (collide || rd_busy_err || wr_line_err) proto_err <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Line store: four 64-bit banks, one per beat position, registered read.
  // The bank is read every cycle at the request line; the registered word is
  // only consumed when a read was accepted on that edge, so a read sees every
  // write beat accepted before it and none accepted after it.
  // ---------------------------------------------------------------------------
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_bank
    logic [63:0] mem [MEM_LINES];
    logic [63:0] word_reg;

    // Beat write straight into its bank; snapshot read of the requested line.
    always_ff @(posedge clk) begin
      if (wr_do && (wr_cnt == 2'(gi))) mem[wr_tgt] <= bus.bmem_wdata;
      word_reg <= mem[req_line];
    end
  end

  assign snap = {g_bank[3].word_reg, g_bank[2].word_reg,
                 g_bank[1].word_reg, g_bank[0].word_reg};

  // ---------------------------------------------------------------------------
  // Outstanding-read queue
  // ---------------------------------------------------------------------------

  // Pointer and occupancy bookkeeping; reset flushes the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      fill_pend <= 1'b0;
      fill_ptr  <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      fill_pend <= push;
      fill_ptr  <= tail;
    end
  end

  // Entry payload: address at accept, line data one edge later from the bank.
  always_ff @(posedge clk) begin
    if (push)      q_addr[tail]     <= bus.bmem_addr[31:5];
    if (fill_pend) q_data[fill_ptr] <= snap;
  end

  for (gi = 0; gi < RD_DEPTH; gi++) begin : g_ent
    logic [TMR_W-1:0] timer_reg;

    // Per-entry latency timer: loaded on push, counts down and holds at 0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        timer_reg <= '0;
      else if (push && (tail == PTR_W'(gi)))
        timer_reg <= TMR_W'(LATENCY);
      else if (timer_reg != '0)
        timer_reg <= timer_reg - TMR_W'(1);
    end

    assign timer_of[gi] = timer_reg;
  end

  // An entry is due when its timer reaches 0 on the coming edge, so beat 0 is
  // driven exactly LATENCY edges after the accepting edge.
  logic [PTR_W-1:0] next_idx;
  logic             head_due;
  logic             next_due;

  assign next_idx = head + PTR_W'(1);
  assign head_due = (count != '0)        && (timer_of[head]     <= TMR_W'(1));
  assign next_due = (count > CNT_W'(1))  && (timer_of[next_idx] <= TMR_W'(1));

  // ---------------------------------------------------------------------------
  // Optional beat gaps
  // ---------------------------------------------------------------------------
`ifdef BMEM_BEAT_GAP_EN
  logic [7:0] lfsr;

  // x^8+x^6+x^5+x^4+1 Fibonacci LFSR, free-running every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 8'hA5;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Return FSM
  // ---------------------------------------------------------------------------

  // State register; async reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= 2'd0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
    end
  end

  // Next state: start on a due head, chain lines without a bubble when the
  // following entry is already due at the end of the current line.
  always_comb begin
    state_next = state;
    beat_next  = beat;
    case (state)
      IDLE: begin
        if (head_due) begin
          state_next = BURST;
          beat_next  = 2'd0;
        end
      end
      BURST: begin
        if (!stall) begin
          beat_next = beat + 2'd1;
          if (beat == 2'd3) state_next = next_due ? BURST : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: beat data and address are zero whenever no beat is presented.
  always_comb begin
    bus.bmem_rvalid = 1'b0;
    bus.bmem_raddr  = 32'd0;
    bus.bmem_rdata  = 64'd0;
    pop             = 1'b0;
    if ((state == BURST) && !stall) begin
      bus.bmem_rvalid = 1'b1;
      bus.bmem_raddr  = {q_addr[head], 5'd0};
      bus.bmem_rdata  = q_data[head][{beat, 6'd0} +: 64];
      pop             = (beat == 2'd3);
    end
  end

endmodule

// File: tb/tb_bmem_burst_responder.sv
// Scoreboard bench for bmem_burst_responder (default build, no beat gaps).
// Reads push their four expected beats (address, data, cycle) into a queue;
// an independent monitor pops and compares whenever rvalid is seen.
module tb_bmem_burst_responder;
  localparam int L = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic proto_err;

  bmem_burst_responder_if bus();

  bmem_burst_responder #(.MEM_LINES(1024), .RD_DEPTH(4), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    int          at;
    string       name;
  } beat_t;

  beat_t            exp_q[$];
  beat_t            mon_e;
  int               total = 0;
  int               bad = 0;
  int               last_end = -100;
  logic [255:0]     mem_model [int];

  function automatic logic [63:0] pat(input logic [15:0] tag, input int k);
    return {tag, 16'h5A5A, 16'(k), ~tag};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end else begin
      $display("check %s ok: %h", nm, act);
    end
  endtask

  // Monitor: every presented beat must match the next expected one exactly.
  always @(negedge clk) begin
    if (rst_n && bus.bmem_rvalid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat: raddr=%h rdata=%h cyc=%0d want none",
                 bus.bmem_raddr, bus.bmem_rdata, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.bmem_raddr !== mon_e.addr || bus.bmem_rdata !== mon_e.data || cyc != mon_e.at) begin
          bad++;
          $display("FAIL beat_%s: raddr=%h rdata=%h cyc=%0d want raddr=%h rdata=%h cyc=%0d",
                   mon_e.name, bus.bmem_raddr, bus.bmem_rdata, cyc, mon_e.addr, mon_e.data, mon_e.at);
        end else begin
          $display("beat %s ok: raddr=%h rdata=%h cyc=%0d", mon_e.name, bus.bmem_raddr, bus.bmem_rdata, cyc);
        end
      end
    end
  end

  // All driver tasks start and end at posedge+1.
  task automatic wait_ready();
    int n = 0;
    while (bus.bmem_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL ready_timeout: ready=%b want 1", bus.bmem_ready);
    end
  endtask

  task automatic wr_beat(input logic [31:0] a, input logic [63:0] d, input int k);
    int line;
    logic [255:0] tmp;
    line = int'((a >> 5) & 32'd1023);
    wait_ready();
    bus.bmem_write = 1'b1;
    bus.bmem_addr  = a;
    bus.bmem_wdata = d;
    @(posedge clk); #1;
    bus.bmem_write = 1'b0;
    tmp = mem_model.exists(line) ? mem_model[line] : 256'd0;
    tmp[64*k +: 64] = d;
    mem_model[line] = tmp;
    $display("write beat %0d addr=%h data=%h", k, a, d);
  endtask

  task automatic wr_line(input logic [31:0] a, input logic [15:0] tag);
    for (int k = 0; k < 4; k++) wr_beat(a, pat(tag, k), k);
  endtask

  task automatic rd(input logic [31:0] a, input string nm, output int acc);
    int line, start;
    logic [255:0] d;
    beat_t e;
    line = int'((a >> 5) & 32'd1023);
    d = mem_model.exists(line) ? mem_model[line] : 256'd0;
    wait_ready();
    bus.bmem_read = 1'b1;
    bus.bmem_addr = a;
    @(posedge clk); #1;
    bus.bmem_read = 1'b0;
    acc = cyc;
    start = (acc + L > last_end + 1) ? acc + L : last_end + 1;
    for (int k = 0; k < 4; k++) begin
      e.addr = {a[31:5], 5'd0};
      e.data = d[64*k +: 64];
      e.at   = start + k;
      e.name = $sformatf("%s_b%0d", nm, k);
      exp_q.push_back(e);
    end
    last_end = start + 3;
    $display("read %s addr=%h accepted cyc=%0d", nm, a, acc);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, a3, free_cyc;
    bus.bmem_read = 1'b0; bus.bmem_write = 1'b0;
    bus.bmem_addr = 32'd0; bus.bmem_wdata = 64'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",  64'(bus.bmem_ready), 64'd0);
    chk("rst_rvalid", 64'(bus.bmem_rvalid), 64'd0);
    chk("rst_raddr",  64'(bus.bmem_raddr), 64'd0);
    chk("rst_rdata",  bus.bmem_rdata, 64'd0);
    chk("rst_perr",   64'(proto_err), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(bus.bmem_ready), 64'd1);

    // Write line 0x40 then read it back after LATENCY
    wr_line(32'h40, 16'h0040);
    rd(32'h40, "t1", a0);
    wait_drain();

    // Fill the queue with four reads; in-order, contiguous 16 beats
    wr_line(32'h00, 16'h1000);
    wr_line(32'h20, 16'h0020);
    wr_line(32'h60, 16'h0060);
    rd(32'h00, "f0", a0);
    rd(32'h20, "f1", a1);
    rd(32'h40, "f2", a2);
    rd(32'h60, "f3", a3);
    chk("fill_back_to_back", 64'(a3 - a0), 64'd3);
    chk("full_ready_low", 64'(bus.bmem_ready), 64'd0);
    free_cyc = a0 + L + 4;
    while (cyc < free_cyc - 1) begin @(posedge clk); #1; end
    chk("ready_low_before_pop", 64'(bus.bmem_ready), 64'd0);
    @(posedge clk); #1;
    chk("ready_after_pop", 64'(bus.bmem_ready), 64'd1);
    wait_drain();

    // Read-before-write ordering on line 0x80
    wr_line(32'h80, 16'h0080);
    rd(32'h80, "old", a0);
    wr_line(32'h80, 16'h0880);
    rd(32'h80, "new", a1);
    wait_drain();

    // Address alias: 0x0001_0020 maps to line 1
    rd(32'h0001_0020, "alias", a0);
    wait_drain();

    // Read while a write burst is open: error, read dropped, write completes
    chk("perr_clear", 64'(proto_err), 64'd0);
    wr_beat(32'hA0, pat(16'h00A0, 0), 0);
    wr_beat(32'hA0, pat(16'h00A0, 1), 1);
    bus.bmem_read = 1'b1; bus.bmem_addr = 32'hA0;
    @(posedge clk); #1;
    bus.bmem_read = 1'b0;
    chk("perr_rd_busy", 64'(proto_err), 64'd1);
    wr_beat(32'hA0, pat(16'h00A0, 2), 2);
    wr_beat(32'hA0, pat(16'h00A0, 3), 3);
    rd(32'hA0, "wdone", a0);
    wait_drain();
    chk("perr_sticky", 64'(proto_err), 64'd1);

    // Reset during beat 1 of a burst
    rd(32'h40, "abort", a0);
    while (cyc < a0 + L + 1) begin @(posedge clk); #1; end
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_rvalid", 64'(bus.bmem_rvalid), 64'd0);
    chk("abort_ready",  64'(bus.bmem_ready), 64'd0);
    chk("abort_perr",   64'(proto_err), 64'd0);
    exp_q.delete();
    last_end = -100;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready_release", 64'(bus.bmem_ready), 64'd1);
    repeat (12) begin @(posedge clk); #1; end
    rd(32'h60, "post_rst", a0);
    wait_drain();

    // Read and write in the same cycle: both dropped, error raised
    bus.bmem_read = 1'b1; bus.bmem_write = 1'b1;
    bus.bmem_addr = 32'h40; bus.bmem_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    bus.bmem_read = 1'b0; bus.bmem_write = 1'b0;
    chk("perr_collide", 64'(proto_err), 64'd1);
    rd(32'h40, "nocorrupt", a0);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
